// File: rtl/ysyx_041461_pipe_ctrl_pkg.sv
// ysyx_041461_pipe_ctrl_pkg: shared ysyx_041461 defines (pipeline controller state encoding)
package ysyx_041461_pipe_ctrl_pkg;
    typedef enum logic {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } pipe_state_e;
endpackage

// File: rtl/ysyx_041461_hazard_detect.sv
// ysyx_041461_hazard_detect: flags an ID instruction that reads the destination of a load still in EXE
module ysyx_041461_hazard_detect
    import ysyx_041461_pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       exe_valid,
    input  logic       exe_is_load,
    input  logic [4:0] exe_rd,
    output logic       load_use
);
    logic rs_hit;
    assign rs_hit   = (id_rs1_used && id_rs1 == exe_rd) || (id_rs2_used && id_rs2 == exe_rd);
    assign load_use = exe_valid && exe_is_load && exe_rd != 5'd0 && id_valid && rs_hit;
endmodule

// File: rtl/ysyx_041461_pipe_ctrl.sv
// ysyx_041461_pipe_ctrl: five-stage pipeline stall/flush controller with divider handshake.
// Define YSYX_041461_PIPE_PERF_EN to build the saturating stall/load-use counters.
module ysyx_041461_pipe_ctrl
    import ysyx_041461_pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             exe_valid,
    input  logic             exe_is_load,
    input  logic             exe_div,
    input  logic [4:0]       exe_rd,
    input  logic             exe_redirect,
    input  logic             div_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             wb_trap,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             id_bubble,
    output logic             exe_bubble,
    output logic             mem_bubble,
    output logic             wb_bubble,
    output logic             div_start,
    output logic             div_kill,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] loaduse_cnt
);
    pipe_state_e state, state_nx;
    logic load_use, mem_stall, lu_act;

    ysyx_041461_hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .exe_valid   (exe_valid),
        .exe_is_load (exe_is_load),
        .exe_rd      (exe_rd),
        .load_use    (load_use)
    );

    assign mem_stall = mem_req && !mem_ready;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= RUN;
        else      state <= state_nx;

    // The div launch cycle already holds EXE so the div instruction stays put while the divider runs
    always_comb begin
        state_nx   = state;
        if_en      = 1'b1;
        id_en      = 1'b1;
        exe_en     = 1'b1;
        mem_en     = 1'b1;
        wb_en      = 1'b1;
        id_bubble  = 1'b0;
        exe_bubble = 1'b0;
        mem_bubble = 1'b0;
        wb_bubble  = 1'b0;
        div_start  = 1'b0;
        div_kill   = 1'b0;
        lu_act     = 1'b0;
        if (!rst) begin
            {if_en, id_en, exe_en, mem_en, wb_en} = 5'b0;
        end else if (wb_trap) begin
            {id_bubble, exe_bubble, mem_bubble, wb_bubble} = 4'b1111;
            div_kill = state == DIV_WAIT;
            state_nx = RUN;
        end else if (mem_stall) begin
            {if_en, id_en, exe_en, mem_en} = 4'b0;
            wb_bubble = 1'b1;
        end else if ((state == DIV_WAIT && !div_done) || (state == RUN && exe_valid && exe_div)) begin
            {if_en, id_en, exe_en} = 3'b0;
            mem_bubble = 1'b1;
            div_start  = state == RUN;
            state_nx   = DIV_WAIT;
        end else begin
            state_nx = RUN;
            if (load_use) begin
                {if_en, id_en} = 2'b0;
                exe_bubble = 1'b1;
                lu_act     = 1'b1;
            end else if (exe_redirect) begin
                {id_bubble, exe_bubble} = 2'b11;
            end
        end
    end

`ifdef YSYX_041461_PIPE_PERF_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            stall_cnt   <= '0;
            loaduse_cnt <= '0;
        end else begin
            if (!if_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (lu_act && loaduse_cnt != '1) loaduse_cnt <= loaduse_cnt + CNT_W'(1);
        end
`else
    assign stall_cnt   = '0;
    assign loaduse_cnt = '0;
`endif
endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// tb_ysyx_041461_pipe_ctrl: directed scenarios plus randomized traffic checked against an event-table model
module tb_ysyx_041461_pipe_ctrl;
    localparam int CW = 4;
`ifdef YSYX_041461_PIPE_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif
    localparam int E_RST = 0, E_TRAP = 1, E_MEM = 2, E_DIV = 3, E_LU = 4, E_RED = 5, E_NONE = 6;
    localparam logic [10:0] IDLE = 11'b11111_0000_00;

    logic clk, rst;
    logic id_valid, id_rs1_used, id_rs2_used;
    logic [4:0] id_rs1, id_rs2, exe_rd;
    logic exe_valid, exe_is_load, exe_div, exe_redirect, div_done, mem_req, mem_ready, wb_trap;
    logic if_en, id_en, exe_en, mem_en, wb_en;
    logic id_bubble, exe_bubble, mem_bubble, wb_bubble, div_start, div_kill;
    logic [CW-1:0] stall_cnt, loaduse_cnt;

    int checks = 0, failures = 0;
    logic run = 0;

    ysyx_041461_pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .exe_valid(exe_valid), .exe_is_load(exe_is_load), .exe_div(exe_div), .exe_rd(exe_rd),
        .exe_redirect(exe_redirect), .div_done(div_done),
        .mem_req(mem_req), .mem_ready(mem_ready), .wb_trap(wb_trap),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .id_bubble(id_bubble), .exe_bubble(exe_bubble), .mem_bubble(mem_bubble), .wb_bubble(wb_bubble),
        .div_start(div_start), .div_kill(div_kill),
        .stall_cnt(stall_cnt), .loaduse_cnt(loaduse_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {if_en, id_en, exe_en, mem_en, wb_en, id_bubble, exe_bubble, mem_bubble, wb_bubble, div_start, div_kill};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        {id_valid, id_rs1_used, id_rs2_used, exe_valid, exe_is_load, exe_div} = '0;
        {exe_redirect, div_done, mem_req, mem_ready, wb_trap} = '0;
        id_rs1 = 0; id_rs2 = 0; exe_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {enables, bubbles} for each winning event, straight from the priority rules
    function automatic logic [8:0] table_of(input int ev);
        case (ev)
            E_RST:   return 9'b00000_0000;
            E_TRAP:  return 9'b11111_1111;
            E_MEM:   return 9'b00001_0001;
            E_DIV:   return 9'b00011_0010;
            E_LU:    return 9'b00111_0100;
            E_RED:   return 9'b11111_1100;
            default: return 9'b11111_0000;
        endcase
    endfunction

    // Reference model: div_busy says whether the divider owns EXE; counters track the registered values
    logic div_busy = 0;
    int m_stall = 0, m_lu = 0;
    always @(negedge clk) if (run) begin
        int ev;
        logic lu;
        logic [8:0] eb;
        lu = exe_valid && exe_is_load && exe_rd != 0 && id_valid &&
             ((id_rs1_used && id_rs1 == exe_rd) || (id_rs2_used && id_rs2 == exe_rd));
        if (!rst) ev = E_RST;
        else if (wb_trap) ev = E_TRAP;
        else if (mem_req && !mem_ready) ev = E_MEM;
        else if ((div_busy && !div_done) || (!div_busy && exe_valid && exe_div)) ev = E_DIV;
        else if (lu) ev = E_LU;
        else if (exe_redirect) ev = E_RED;
        else ev = E_NONE;
        eb = table_of(ev);
        if (!rst) begin
            m_stall = 0;
            m_lu = 0;
        end
        chk("model_outs", outs(), {eb, ev == E_DIV && !div_busy, ev == E_TRAP && div_busy});
        chk("model_stall_cnt", stall_cnt, PERF * m_stall);
        chk("model_loaduse_cnt", loaduse_cnt, PERF * m_lu);
        if (!rst) div_busy = 0;
        else if (ev != E_MEM) div_busy = ev == E_DIV;
        if (rst) begin
            if (!eb[8] && m_stall < (1 << CW) - 1) m_stall++;
            if (ev == E_LU && m_lu < (1 << CW) - 1) m_lu++;
        end
    end

    initial begin
        clk = 0;
        idle();
        rst = 0;
        run = 1;
        repeat (2) @(negedge clk);
        chk("reset_outs", outs(), 0);
        chk("reset_cnt", {stall_cnt, loaduse_cnt}, 0);
        tick(); rst = 1;
        @(negedge clk);
        chk("no_event", outs(), IDLE);
        // load-use on rs1
        tick(); exe_valid = 1; exe_is_load = 1; exe_rd = 5; id_valid = 1; id_rs1_used = 1; id_rs1 = 5;
        @(negedge clk);
        chk("lu_stall", outs(), 11'b00111_0100_00);
        tick(); idle();
        @(negedge clk);
        chk("lu_release", outs(), IDLE);
        chk("lu_cnt", loaduse_cnt, PERF * 1);
        chk("lu_stall_cnt", stall_cnt, PERF * 1);
        // x0 never hazards
        tick(); exe_valid = 1; exe_is_load = 1; exe_rd = 0; id_valid = 1; id_rs1_used = 1; id_rs1 = 0;
        @(negedge clk);
        chk("lu_x0", outs(), IDLE);
        // divide with done 10 cycles after start
        tick(); idle(); exe_valid = 1; exe_div = 1;
        @(negedge clk);
        chk("div_start", outs(), 11'b00011_0010_10);
        for (int i = 1; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("div_wait", outs(), 11'b00011_0010_00);
        end
        tick(); div_done = 1;
        @(negedge clk);
        chk("div_done", outs(), IDLE);
        tick(); idle();
        @(negedge clk);
        chk("div_stall_cnt", stall_cnt, PERF * 11);
        chk("div_back_run", outs(), IDLE);
        // mem stall 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick(); mem_req = 1; mem_ready = 0;
            @(negedge clk);
            chk("mem_stall", outs(), 11'b00001_0001_00);
        end
        tick(); mem_ready = 1;
        @(negedge clk);
        chk("mem_done", outs(), IDLE);
        tick(); idle();
        @(negedge clk);
        chk("mem_stall_cnt", stall_cnt, PERF * 14);
        // trap while waiting on the divider
        tick(); exe_valid = 1; exe_div = 1;
        repeat (2) tick();
        tick(); wb_trap = 1;
        @(negedge clk);
        chk("trap_kill", outs(), 11'b11111_1111_01);
        tick(); idle();
        @(negedge clk);
        chk("trap_run", outs(), IDLE);
        chk("stall_sat", stall_cnt, PERF * 15);
        // reset while waiting on the divider
        tick(); exe_valid = 1; exe_div = 1;
        tick();
        tick(); rst = 0;
        @(negedge clk);
        chk("rst_div_outs", outs(), 0);
        chk("rst_div_cnt", {stall_cnt, loaduse_cnt}, 0);
        tick(); rst = 1; idle();
        @(negedge clk);
        chk("rst_run", outs(), IDLE);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst          = $urandom_range(0, 99) != 0;
            wb_trap      = $urandom_range(0, 15) == 0;
            mem_req      = $urandom_range(0, 3) == 0;
            mem_ready    = $urandom_range(0, 1) == 0;
            exe_valid    = $urandom_range(0, 3) != 0;
            exe_div      = $urandom_range(0, 7) == 0;
            exe_is_load  = !exe_div && $urandom_range(0, 2) == 0;
            exe_redirect = !exe_div && !exe_is_load && $urandom_range(0, 7) == 0;
            div_done     = $urandom_range(0, 5) == 0;
            exe_rd       = 5'($urandom_range(0, 3));
            id_valid     = $urandom_range(0, 3) != 0;
            id_rs1_used  = $urandom_range(0, 1) == 0;
            id_rs2_used  = $urandom_range(0, 1) == 0;
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
        end
        tick();
        @(negedge clk);
        run = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_041461_pipe_ctrl.md
YSYX_041461_PIPE_CTRL -- requirements
Module: ysyx_041461_pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: CNT_W, 32, width of performance counters.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst  in  1  asynchronous active-low reset.
REQ-005 Port: id_valid, id_rs1_used, id_rs2_used  in  1 each  ID instruction valid and source use flags.
REQ-006 Port: id_rs1, id_rs2  in  5 each  ID source register numbers.
REQ-007 Port: exe_valid, exe_is_load, exe_div  in  1 each  EXE valid, load, and multi-cycle div/rem.
REQ-008 Port: exe_rd  in  5  EXE destination register.
REQ-009 Port: exe_redirect  in  1  branch/jump taken in EXE.
REQ-010 Port: div_done  in  1  divider result valid pulse.
REQ-011 Port: mem_req, mem_ready  in  1 each  MEM-stage bus request and completion.
REQ-012 Port: wb_trap  in  1  trap/mret commit in WB.
REQ-013 Port: if_en, id_en, exe_en, mem_en, wb_en  out  1 each  pipeline register enables.
REQ-014 Port: id_bubble, exe_bubble, mem_bubble, wb_bubble  out  1 each  force valid_in=0 on that register.
REQ-015 Port: div_start, div_kill  out  1 each  divider launch/abort pulses.
REQ-016 Port: stall_cnt, loaduse_cnt  out  CNT_W each  performance counters.

Function
REQ-017 FSM states SHALL be RUN, DIV_WAIT; priority per cycle: wb_trap > mem stall > DIV_WAIT > load-use > exe_redirect.
REQ-018 Mem stall (mem_req & !mem_ready) SHALL drive if/id/exe/mem_en=0, wb_en=1, wb_bubble=1; mem_req & mem_ready same cycle SHALL not stall.
REQ-019 Load-use (exe_valid & exe_is_load & exe_rd!=0 & id_valid & matching used rs) SHALL drive if_en=id_en=0, exe_en=1, exe_bubble=1 for one cycle.
REQ-020 exe_redirect SHALL drive all enables 1, id_bubble=exe_bubble=1.
REQ-021 RUN with exe_valid & exe_div & no higher event SHALL pulse div_start one cycle and go DIV_WAIT next cycle.
REQ-022 DIV_WAIT SHALL drive if/id/exe_en=0, mem_en=1, mem_bubble=1 until div_done; div_done SHALL release enables combinationally that cycle and return to RUN.
REQ-023 wb_trap SHALL drive all enables 1, id/exe/mem/wb_bubble=1; in DIV_WAIT also pulse div_kill and go RUN.
REQ-024 div_done in RUN SHALL be ignored.
REQ-025 No event: all enables 1, all bubbles 0.

Reset
REQ-026 While rst=0: state RUN, all enables 0, all bubbles 0, div_start=div_kill=0, counters 0.
REQ-027 Reset mid-DIV_WAIT SHALL return to RUN without div_kill.

Configuration
REQ-028 With YSYX_041461_PIPE_PERF_EN defined, stall_cnt SHALL increment each cycle if_en=0, loaduse_cnt each load-use cycle, both saturating at all-ones.
REQ-029 Without YSYX_041461_PIPE_PERF_EN, both counters SHALL be constant 0 with no flops.

Structure
REQ-030 State encodings SHALL reside in the shared ysyx_041461 defines file.
REQ-031 Load-use compare SHALL be a sub-module ysyx_041461_hazard_detect.

Verification
REQ-032 exe load rd=5, id rs1=5 used -> one cycle if_en=id_en=0, exe_bubble=1, loaduse_cnt=1.
REQ-033 exe load rd=0, id rs1=0 -> no stall.
REQ-034 exe_div; div_done 10 cycles after div_start -> DIV_WAIT for 10 cycles, mem_bubble=1 throughout, stall_cnt=10.
REQ-035 mem_req with mem_ready after 3 cycles -> 3 stall cycles, wb_bubble=1 each, then resume.
REQ-036 wb_trap in DIV_WAIT -> div_kill one cycle, all bubbles 1, RUN next cycle.
REQ-037 rst low during DIV_WAIT -> RUN, outputs at reset values, div_kill=0.
